// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station, collapsing queue with CDB wakeup and oldest-ready issue
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [15:0]                disp_pc,
    input  logic [3:0]                 disp_opcode,
    input  logic [15:0]                disp_opr1,
    input  logic [15:0]                disp_opr2,
    input  logic                       disp_opr1_rdy,
    input  logic                       disp_opr2_rdy,
    input  logic [TAG_W-1:0]           disp_tag1,
    input  logic [TAG_W-1:0]           disp_tag2,
    input  logic [TAG_W-1:0]           disp_rrf_dest,
    input  logic [1:0]                 disp_cz,
    input  logic                       disp_cmp,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [15:0]                cdb_data,
    output logic [15:0]                pc_out,
    output logic [3:0]                 opcode_out,
    output logic [15:0]                opr1_out,
    output logic [15:0]                opr2_out,
    output logic [TAG_W-1:0]           rrf_dest_out,
    output logic [1:0]                 cz_out,
    output logic                       cmp_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic             busy;
        logic [15:0]      pc;
        logic [3:0]       opcode;
        logic [15:0]      opr1;
        logic [15:0]      opr2;
        logic             rdy1;
        logic             rdy2;
        logic [TAG_W-1:0] tag1;
        logic [TAG_W-1:0] tag2;
        logic [TAG_W-1:0] dest;
        logic [1:0]       cz;
        logic             cmp;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_w [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          nent;
    logic            issue;
    logic [IW-1:0]   sel;
    logic            do_disp;
    logic [CW-1:0]   wr_idx;
    logic [CW-1:0]   count_d;

    assign disp_ready = (count != CW'(DEPTH));
    assign do_disp    = disp_valid && disp_ready;
    assign wr_idx     = issue ? count - CW'(1) : count;

    // Oldest-ready select, looking only at registered state so fresh wakeups wait a cycle
    always_comb begin
        issue = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!issue && ent_q[i].busy && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                issue = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    // New entry from dispatch, with same-cycle CDB bypass for waiting operands
    always_comb begin
        nent        = '0;
        nent.busy   = 1'b1;
        nent.pc     = disp_pc;
        nent.opcode = disp_opcode;
        nent.opr1   = disp_opr1;
        nent.opr2   = disp_opr2;
        nent.rdy1   = disp_opr1_rdy;
        nent.rdy2   = disp_opr2_rdy;
        nent.tag1   = disp_tag1;
        nent.tag2   = disp_tag2;
        nent.dest   = disp_rrf_dest;
        nent.cz     = disp_cz;
        nent.cmp    = disp_cmp;
        if (cdb_valid && !disp_opr1_rdy && disp_tag1 == cdb_tag) begin
            nent.rdy1 = 1'b1;
            nent.opr1 = cdb_data;
        end
        if (cdb_valid && !disp_opr2_rdy && disp_tag2 == cdb_tag) begin
            nent.rdy2 = 1'b1;
            nent.opr2 = cdb_data;
        end
    end

    // Apply CDB wakeup in place, then collapse over the issued slot and append the dispatch
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            if (cdb_valid && ent_q[i].busy && !ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
                ent_w[i].rdy1 = 1'b1;
                ent_w[i].opr1 = cdb_data;
            end
            if (cdb_valid && ent_q[i].busy && !ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
                ent_w[i].rdy2 = 1'b1;
                ent_w[i].opr2 = cdb_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_w[i];
            if (issue && i >= int'(sel)) begin
                ent_d[i] = (i < DEPTH - 1) ? ent_w[(i + 1) % DEPTH] : '0;
            end
            if (do_disp && wr_idx == CW'(i)) begin
                ent_d[i] = nent;
            end
        end
    end

    // Occupancy: dispatch and issue in the same cycle cancel out
    always_comb begin
        case ({do_disp, issue})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // State and issued bundle registers; flush drops everything but leaves bundle fields as-is
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count        <= '0;
            valid_out    <= 1'b0;
            pc_out       <= '0;
            opcode_out   <= '0;
            opr1_out     <= '0;
            opr2_out     <= '0;
            rrf_dest_out <= '0;
            cz_out       <= '0;
            cmp_out      <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count     <= '0;
            valid_out <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count     <= count_d;
            valid_out <= issue;
            if (issue) begin
                pc_out       <= ent_q[sel].pc;
                opcode_out   <= ent_q[sel].opcode;
                opr1_out     <= ent_q[sel].opr1;
                opr2_out     <= ent_q[sel].opr2;
                rrf_dest_out <= ent_q[sel].dest;
                cz_out       <= ent_q[sel].cz;
                cmp_out      <= ent_q[sel].cmp;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [15:0] disp_pc;
    logic [3:0]  disp_opcode;
    logic [15:0] disp_opr1, disp_opr2;
    logic        disp_opr1_rdy, disp_opr2_rdy;
    logic [4:0]  disp_tag1, disp_tag2, disp_rrf_dest;
    logic [1:0]  disp_cz;
    logic        disp_cmp;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic [15:0] pc_out;
    logic [3:0]  opcode_out;
    logic [15:0] opr1_out, opr2_out;
    logic [4:0]  rrf_dest_out;
    logic [1:0]  cz_out;
    logic        cmp_out;
    logic        valid_out;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_opcode(disp_opcode),
        .disp_opr1(disp_opr1), .disp_opr2(disp_opr2),
        .disp_opr1_rdy(disp_opr1_rdy), .disp_opr2_rdy(disp_opr2_rdy),
        .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_rrf_dest(disp_rrf_dest), .disp_cz(disp_cz), .disp_cmp(disp_cmp),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .pc_out(pc_out), .opcode_out(opcode_out),
        .opr1_out(opr1_out), .opr2_out(opr2_out),
        .rrf_dest_out(rrf_dest_out), .cz_out(cz_out), .cmp_out(cmp_out),
        .valid_out(valid_out), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [15:0] pc, input logic [3:0] op,
                        input logic [15:0] o1, input logic r1, input logic [4:0] t1,
                        input logic [15:0] o2, input logic r2, input logic [4:0] t2,
                        input logic [4:0] dest);
        disp_valid    = 1'b1;
        disp_pc       = pc;
        disp_opcode   = op;
        disp_opr1     = o1;
        disp_opr1_rdy = r1;
        disp_tag1     = t1;
        disp_opr2     = o2;
        disp_opr2_rdy = r2;
        disp_tag2     = t2;
        disp_rrf_dest = dest;
    endtask

    task automatic bcast(input logic [4:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; disp_valid = 1'b0; disp_pc = '0; disp_opcode = '0;
        disp_opr1 = '0; disp_opr2 = '0; disp_opr1_rdy = 1'b0; disp_opr2_rdy = 1'b0;
        disp_tag1 = '0; disp_tag2 = '0; disp_rrf_dest = '0; disp_cz = 2'd2; disp_cmp = 1'b1;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid", valid_out, 0);
        check("rst_count", count, 0);
        check("rst_ready", disp_ready, 1);
        check("rst_pc", pc_out, 0);
        check("rst_opr1", opr1_out, 0);

        // ready dispatch
        disp(16'h0010, 4'b0001, 16'd5, 1, 5'd0, 16'd7, 1, 5'd0, 5'd3);
        step(); idle();
        check("rdy_cnt1", count, 1);
        check("rdy_v0", valid_out, 0);
        step();
        check("rdy_valid", valid_out, 1);
        check("rdy_pc", pc_out, 16'h0010);
        check("rdy_op", opcode_out, 4'b0001);
        check("rdy_opr1", opr1_out, 5);
        check("rdy_opr2", opr2_out, 7);
        check("rdy_dest", rrf_dest_out, 3);
        check("rdy_cz", cz_out, 2);
        check("rdy_cmp", cmp_out, 1);
        check("rdy_cnt0", count, 0);
        step();
        check("rdy_vdrop", valid_out, 0);
        check("rdy_hold", opr1_out, 5);

        // CDB wakeup
        disp(16'h0011, 4'b0010, 16'h0, 0, 5'd9, 16'd3, 1, 5'd0, 5'd4);
        step(); idle();
        check("wk_cnt", count, 1);
        check("wk_wait0", valid_out, 0);
        step();
        check("wk_wait1", valid_out, 0);
        bcast(5'd9, 16'hAAAA);
        step(); idle();
        check("wk_notyet", valid_out, 0);
        step();
        check("wk_valid", valid_out, 1);
        check("wk_opr1", opr1_out, 16'hAAAA);
        check("wk_opr2", opr2_out, 3);
        check("wk_op", opcode_out, 4'b0010);
        check("wk_cnt0", count, 0);

        // dispatch bypass
        disp(16'h0012, 4'b0001, 16'h0011, 1, 5'd0, 16'h0, 0, 5'd4, 5'd5);
        bcast(5'd4, 16'h1234);
        step(); idle();
        check("byp_cnt", count, 1);
        step();
        check("byp_valid", valid_out, 1);
        check("byp_opr2", opr2_out, 16'h1234);
        check("byp_opr1", opr1_out, 16'h0011);

        // age order: fill with entries waiting on tag 7
        step();
        for (int i = 1; i <= 4; i++) begin
            disp(16'(i), 4'b0001, 16'h0, 0, 5'd7, 16'd1, 1, 5'd0, 5'(i));
            step();
        end
        idle();
        check("age_full_cnt", count, 4);
        check("age_full_rdy", disp_ready, 0);
        disp(16'd99, 4'b0001, 16'd1, 1, 5'd0, 16'd1, 1, 5'd0, 5'd9);
        step(); idle();
        check("age_ignored", count, 4);
        check("age_nov", valid_out, 0);
        bcast(5'd7, 16'h0777);
        step(); idle();
        check("age_wake_cnt", count, 4);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("age_valid", valid_out, 1);
            check("age_pc", pc_out, i);
            check("age_cnt", count, 4 - i);
        end
        step();
        check("age_empty_v", valid_out, 0);

        // simultaneous dispatch and issue at count 2
        disp(16'h0020, 4'b0001, 16'h0, 0, 5'd12, 16'd1, 1, 5'd0, 5'd1);
        step();
        disp(16'h0021, 4'b0001, 16'h0, 0, 5'd13, 16'd1, 1, 5'd0, 5'd2);
        step(); idle();
        check("sim_cnt2", count, 2);
        bcast(5'd12, 16'h00C0);
        step(); idle();
        disp(16'h0022, 4'b0001, 16'd1, 1, 5'd0, 16'd2, 1, 5'd0, 5'd3);
        step(); idle();
        check("sim_cnt_hold", count, 2);
        check("sim_iss_v", valid_out, 1);
        check("sim_iss_pc", pc_out, 16'h0020);
        check("sim_iss_opr1", opr1_out, 16'h00C0);
        step();
        check("sim_new_pc", pc_out, 16'h0022);
        check("sim_new_cnt", count, 1);
        bcast(5'd13, 16'h00D0);
        step(); idle();
        check("sim_gap_v", valid_out, 0);
        step();
        check("sim_last_pc", pc_out, 16'h0021);
        check("sim_last_cnt", count, 0);

        // flush with 3 entries and an issue pending
        disp(16'h0030, 4'b0001, 16'h0, 0, 5'd20, 16'd1, 1, 5'd0, 5'd1);
        step();
        disp(16'h0031, 4'b0001, 16'h0, 0, 5'd20, 16'd1, 1, 5'd0, 5'd2);
        step();
        disp(16'h0032, 4'b0001, 16'd1, 1, 5'd0, 16'd1, 1, 5'd0, 5'd3);
        step();
        check("fl_pre_cnt", count, 3);
        disp(16'h0040, 4'b0001, 16'd1, 1, 5'd0, 16'd1, 1, 5'd0, 5'd4);
        flush = 1'b1;
        step(); idle();
        check("fl_valid", valid_out, 0);
        check("fl_cnt", count, 0);
        check("fl_ready", disp_ready, 1);
        step();
        check("fl_drop_v", valid_out, 0);
        check("fl_drop_cnt", count, 0);
        bcast(5'd20, 16'h0BAD);
        step(); idle();
        step();
        check("fl_gone", valid_out, 0);

        // asynchronous reset mid-operation
        disp(16'h0050, 4'b0001, 16'd1, 1, 5'd0, 16'd1, 1, 5'd0, 5'd5);
        step(); idle();
        step();
        check("ar_pre_v", valid_out, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", valid_out, 0);
        check("ar_pc", pc_out, 0);
        check("ar_cnt", count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("ar_after_v", valid_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
